// File: rtl/dot_prod_pkg.sv
// Shared types and width derivations for the dot-product scheduler slice.
// No logic here; the state enum and width helpers are used by the scheduler and its bench.
// Widths are derived from the Q-format parameters of each instance.
package dot_prod_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_X  = 3'd2,
        COMPUTE = 3'd3,
        OUT     = 3'd4
    } state_t;

    function automatic int calc_bitwidth(input int qn, input int qm);
        return qn + qm + 1;
    endfunction

    function automatic int calc_mem_bitwidth(input int qn, input int qm, input int nrow);
        return calc_bitwidth(qn, qm) * nrow;
    endfunction

    // Keep at least one address bit so a single-column build still has a port.
    function automatic int calc_addr_bitwidth(input int ncol);
        return (ncol > 1) ? $clog2(ncol) : 1;
    endfunction

endpackage

// File: rtl/input_vec_buf.sv
// Input vector buffer: NCOL x BITWIDTH register file, one write port, one async read port.
// Latency: write visible the cycle after wr_en, read is combinational.
// Backpressure: none; the writer decides when a beat lands.
module input_vec_buf #(
    parameter int NCOL          = 8,
    parameter int BITWIDTH      = 18,
    parameter int ADDR_BITWIDTH = 3
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [ADDR_BITWIDTH-1:0] wr_addr,
    input  logic [BITWIDTH-1:0]      wr_dat,
    input  logic [ADDR_BITWIDTH-1:0] rd_addr,
    output logic [BITWIDTH-1:0]      rd_dat
);

    // Deliberately unreset: every job rewrites all entries before they are read.
    logic [BITWIDTH-1:0] mem_q [NCOL];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/dot_prod_sched.sv
// Job scheduler for a dot_prod engine: loads weights/inputs, runs one computation, hands out the result.
// Latency: weight writes land one cycle after each accepted beat; result captured on first dataReady.
// Backpressure: valid/ready on weight and input streams; result held in OUT until outReady.
module dot_prod_sched
    import dot_prod_pkg::*;
#(
    parameter int NROW    = 16,
    parameter int NCOL    = 8,
    parameter int QN      = 6,
    parameter int QM      = 11,
    parameter int TIMEOUT = 64,
    localparam int BITWIDTH        = calc_bitwidth(QN, QM),
    localparam int MEMORY_BITWIDTH = calc_mem_bitwidth(QN, QM, NROW),
    localparam int ADDR_BITWIDTH   = calc_addr_bitwidth(NCOL)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       loadW,
    input  logic                       wIn_valid,
    output logic                       wIn_ready,
    input  logic [MEMORY_BITWIDTH-1:0] wIn_data,
    input  logic                       xIn_valid,
    output logic                       xIn_ready,
    input  logic [BITWIDTH-1:0]        xIn_data,
    output logic                       writeEn,
    output logic [ADDR_BITWIDTH-1:0]   colAddressWrite,
    output logic [MEMORY_BITWIDTH-1:0] weightMemInput,
    output logic                       dpReset,
    input  logic [ADDR_BITWIDTH-1:0]   colAddressRead,
    output logic [BITWIDTH-1:0]        inputVec,
    input  logic                       dataReady,
    input  logic [MEMORY_BITWIDTH-1:0] outputVec,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [MEMORY_BITWIDTH-1:0] outVec,
    output logic                       busy,
    output logic                       err
);

    // The watchdog must reach TIMEOUT, so it cannot share the column-sized beat counter width.
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t                     state_q, state_d;
    logic [ADDR_BITWIDTH-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]           tmr_q, tmr_d;
    logic                       wr_en_q, wr_en_d;
    logic [ADDR_BITWIDTH-1:0]   col_wr_q, col_wr_d;
    logic [MEMORY_BITWIDTH-1:0] wmem_q, wmem_d;
    logic                       w_rdy_q, w_rdy_d;
    logic                       x_rdy_q, x_rdy_d;
    logic                       dp_rst_q, dp_rst_d;
    logic                       out_vld_q, out_vld_d;
    logic [MEMORY_BITWIDTH-1:0] out_vec_q, out_vec_d;
    logic                       busy_q, busy_d;
    logic                       err_q, err_d;

    logic                       w_beat, x_beat, last_beat;
    logic [BITWIDTH-1:0]        xbuf_rd_dat;

    assign w_beat    = wIn_valid & w_rdy_q;
    assign x_beat    = xIn_valid & x_rdy_q;
    assign last_beat = (cnt_q == ADDR_BITWIDTH'(NCOL - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmr_d     = tmr_q;
        wr_en_d   = 1'b0;
        col_wr_d  = col_wr_q;
        wmem_d    = wmem_q;
        out_vec_d = out_vec_q;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = '0;
                    state_d = loadW ? LOAD_W : LOAD_X;
                end
            end
            LOAD_W: begin
                if (w_beat) begin
                    wr_en_d  = 1'b1;
                    col_wr_d = cnt_q;
                    wmem_d   = wIn_data;
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = LOAD_X;
                    end else begin
                        cnt_d = cnt_q + ADDR_BITWIDTH'(1);
                    end
                end
            end
            LOAD_X: begin
                if (x_beat) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        tmr_d   = '0;
                        state_d = COMPUTE;
                    end else begin
                        cnt_d = cnt_q + ADDR_BITWIDTH'(1);
                    end
                end
            end
            COMPUTE: begin
                // A result arriving on the final allowed cycle still wins over the timeout.
                if (dataReady) begin
                    out_vec_d = outputVec;
                    state_d   = OUT;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            OUT: begin
                if (outReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        w_rdy_d   = (state_d == LOAD_W);
        x_rdy_d   = (state_d == LOAD_X);
        dp_rst_d  = (state_d != COMPUTE);
        out_vld_d = (state_d == OUT);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tmr_q     <= '0;
            wr_en_q   <= 1'b0;
            col_wr_q  <= '0;
            wmem_q    <= '0;
            w_rdy_q   <= 1'b0;
            x_rdy_q   <= 1'b0;
            dp_rst_q  <= 1'b1;
            out_vld_q <= 1'b0;
            out_vec_q <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            wr_en_q   <= wr_en_d;
            col_wr_q  <= col_wr_d;
            wmem_q    <= wmem_d;
            w_rdy_q   <= w_rdy_d;
            x_rdy_q   <= x_rdy_d;
            dp_rst_q  <= dp_rst_d;
            out_vld_q <= out_vld_d;
            out_vec_q <= out_vec_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    input_vec_buf #(
        .NCOL          (NCOL),
        .BITWIDTH      (BITWIDTH),
        .ADDR_BITWIDTH (ADDR_BITWIDTH)
    ) u_xbuf (
        .clock   (clock),
        .wr_en   (x_beat),
        .wr_addr (cnt_q),
        .wr_dat  (xIn_data),
        .rd_addr (colAddressRead),
        .rd_dat  (xbuf_rd_dat)
    );

    assign inputVec        = dp_rst_q ? '0 : xbuf_rd_dat;
    assign wIn_ready       = w_rdy_q;
    assign xIn_ready       = x_rdy_q;
    assign writeEn         = wr_en_q;
    assign colAddressWrite = col_wr_q;
    assign weightMemInput  = wmem_q;
    assign dpReset         = dp_rst_q;
    assign outValid        = out_vld_q;
    assign outVec          = out_vec_q;
    assign busy            = busy_q;
    assign err             = err_q;

endmodule

// File: tb/tb_dot_prod_sched.sv
// Bench for dot_prod_sched: plays the weightRAM and dot_prod engine around the scheduler.
`timescale 1ns/1ps
module tb_dot_prod_sched;

    localparam int NROW    = 16;
    localparam int NCOL    = 8;
    localparam int QN      = 6;
    localparam int QM      = 11;
    localparam int TIMEOUT = 64;
    localparam int BW      = QN + QM + 1;
    localparam int MW      = BW * NROW;
    localparam int AW      = 3;

    logic          clock, reset, start, loadW;
    logic          wIn_valid, wIn_ready, xIn_valid, xIn_ready;
    logic [MW-1:0] wIn_data, weightMemInput, outputVec, outVec;
    logic [BW-1:0] xIn_data, inputVec;
    logic          writeEn, dpReset, dataReady, outValid, outReady, busy, err;
    logic [AW-1:0] colAddressWrite, colAddressRead;

    dot_prod_sched #(
        .NROW(NROW), .NCOL(NCOL), .QN(QN), .QM(QM), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .loadW(loadW),
        .wIn_valid(wIn_valid), .wIn_ready(wIn_ready), .wIn_data(wIn_data),
        .xIn_valid(xIn_valid), .xIn_ready(xIn_ready), .xIn_data(xIn_data),
        .writeEn(writeEn), .colAddressWrite(colAddressWrite), .weightMemInput(weightMemInput),
        .dpReset(dpReset), .colAddressRead(colAddressRead), .inputVec(inputVec),
        .dataReady(dataReady), .outputVec(outputVec), .outValid(outValid),
        .outReady(outReady), .outVec(outVec), .busy(busy), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_i(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_v(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Weight RAM as written by the DUT, plus a log of written columns.
    logic [MW-1:0] ram [NCOL];
    int            wr_cols[$];
    int            wr_overlap = 0;

    always @(negedge clock) begin
        if (writeEn === 1'b1) begin
            ram[colAddressWrite] = weightMemInput;
            wr_cols.push_back(int'(colAddressWrite));
            if (dpReset !== 1'b1) wr_overlap++;
        end
    end

    // What the bench intends: weights it last sent, and the current job's data.
    logic [MW-1:0] model_w [NCOL];
    logic [MW-1:0] job_w   [NCOL];
    logic [BW-1:0] job_x   [NCOL];
    logic [MW-1:0] last_exp;

    // Q(QN.QM) matrix-vector product, each lane truncated to BW bits.
    function automatic logic [MW-1:0] dot_ref(input logic [MW-1:0] w [NCOL], input logic [BW-1:0] x [NCOL]);
        logic [MW-1:0]        r;
        logic signed [BW-1:0] a, b;
        longint               acc;
        r = '0;
        for (int l = 0; l < NROW; l++) begin
            acc = 0;
            for (int c = 0; c < NCOL; c++) begin
                a = w[c][l*BW +: BW];
                b = x[c];
                acc += longint'(a) * longint'(b);
            end
            r[l*BW +: BW] = BW'(acc >>> QM);
        end
        return r;
    endfunction

    task automatic start_and_load(input bit lw, input bit gap);
        int k, cyc;
        bit acc;
        wr_cols.delete();
        start = 1'b1; loadW = lw;
        @(negedge clock);
        start = 1'b0; loadW = 1'b0;
        check_i("busy_after_start", int'(busy), 1);
        if (lw) begin
            k = 0; cyc = 0;
            while (k < NCOL && cyc < 200) begin
                wIn_valid = !(gap && (cyc % 2 == 1));
                wIn_data  = job_w[k];
                acc = wIn_valid && (wIn_ready === 1'b1);
                @(negedge clock);
                if (acc) k++;
                cyc++;
            end
            wIn_valid = 1'b0;
            check_i("w_beats_accepted", k, NCOL);
            check_i("load_x_entry_rdy", int'({wIn_ready, xIn_ready}), 1);
            for (int c = 0; c < NCOL; c++) model_w[c] = job_w[c];
        end
        k = 0; cyc = 0;
        while (k < NCOL && cyc < 200) begin
            xIn_valid = !(gap && (cyc % 2 == 1));
            xIn_data  = job_x[k];
            acc = xIn_valid && (xIn_ready === 1'b1);
            @(negedge clock);
            if (acc) k++;
            cyc++;
        end
        xIn_valid = 1'b0;
        check_i("x_beats_accepted", k, NCOL);
        check_i("compute_entry_dprst_busy", int'({dpReset, busy}), 1);
    endtask

    task automatic compute_and_out(input int hold_out, input int dp_delay, output logic [MW-1:0] got);
        logic [BW-1:0] xs [NCOL];
        int xbad, bad;
        xbad = 0;
        for (int c = 0; c < NCOL; c++) begin
            colAddressRead = AW'(c);
            #1;
            xs[c] = inputVec;
            if (xs[c] !== job_x[c]) xbad++;
            @(negedge clock);
        end
        check_i("inputvec_reads", xbad, 0);
        repeat (dp_delay) @(negedge clock);
        outputVec = dot_ref(ram, xs);
        dataReady = 1'b1;
        @(negedge clock);
        dataReady = 1'b0;
        for (int i = 0; i < MW / 32; i++) outputVec[i*32 +: 32] = $urandom;
        got = outVec;
        check_i("outvalid_after_capture", int'(outValid), 1);
        bad = 0;
        for (int i = 0; i < hold_out; i++) begin
            start = (i % 3 == 0);
            @(negedge clock);
            if (outValid !== 1'b1 || outVec !== got) bad++;
        end
        start = 1'b0;
        check_i("out_hold_stable", bad, 0);
        outReady = 1'b1;
        @(negedge clock);
        outReady = 1'b0;
        check_i("out_release_vld_busy", int'({outValid, busy}), 0);
    endtask

    function automatic int wr_order_bad();
        int bad;
        bad = 0;
        foreach (wr_cols[i]) if (wr_cols[i] != i) bad++;
        return bad;
    endfunction

    typedef struct {
        bit            lw;
        logic [BW-1:0] w;
        logic [BW-1:0] x;
        bit            gap;
        int            hold;
        logic [BW-1:0] exp_lane;
        int            exp_wr;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog_timeout simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl [4];
        logic [MW-1:0] got, expv;
        logic [BW-1:0] lane;
        int            early, k;
        bit            acc;

        tbl[0] = '{1'b1, 18'h00800, 18'h00800, 1'b0, 0,  18'h04000, NCOL};
        tbl[1] = '{1'b0, 18'h00000, 18'h01000, 1'b0, 10, 18'h08000, 0};
        tbl[2] = '{1'b1, 18'h00400, 18'h3F800, 1'b1, 2,  18'h3E000, NCOL};
        tbl[3] = '{1'b0, 18'h00000, 18'h00200, 1'b1, 1,  18'h00800, 0};

        reset = 1'b1; start = 1'b0; loadW = 1'b0;
        wIn_valid = 1'b0; wIn_data = '0; xIn_valid = 1'b0; xIn_data = '0;
        colAddressRead = 3'd5; dataReady = 1'b0; outputVec = '0; outReady = 1'b0;
        repeat (3) @(negedge clock);
        check_i("reset_outputs", int'({busy, writeEn, wIn_ready, xIn_ready, outValid, err, dpReset}), 1);
        check_v("reset_outvec", outVec, '0);
        reset = 1'b0;
        @(negedge clock);

        for (int t = 0; t < 4; t++) begin
            lane = tbl[t].w;
            for (int c = 0; c < NCOL; c++) begin
                job_w[c] = {NROW{lane}};
                job_x[c] = tbl[t].x;
            end
            start_and_load(tbl[t].lw, tbl[t].gap);
            compute_and_out(tbl[t].hold, 2, got);
            lane = tbl[t].exp_lane;
            check_v("tbl_outvec", got, {NROW{lane}});
            check_i("tbl_write_count", wr_cols.size(), tbl[t].exp_wr);
            check_i("tbl_write_order", wr_order_bad(), 0);
            last_exp = {NROW{lane}};
        end

        colAddressRead = 3'd3;
        #1;
        check_i("inputvec_zero_idle", int'(inputVec), 0);

        // Timeout: no dataReady, error after TIMEOUT compute cycles, result untouched.
        for (int c = 0; c < NCOL; c++) job_x[c] = BW'($urandom);
        start_and_load(1'b0, 1'b0);
        early = 0;
        for (int i = 1; i < TIMEOUT; i++) begin
            @(negedge clock);
            if (err !== 1'b0 || busy !== 1'b1) early++;
        end
        check_i("timeout_no_early_err", early, 0);
        @(negedge clock);
        check_i("timeout_err_pulse", int'(err), 1);
        check_v("timeout_outvec_kept", outVec, last_exp);
        @(negedge clock);
        check_i("timeout_after_err_busy", int'({err, busy}), 0);

        // Reset in the middle of a weight load.
        for (int c = 0; c < NCOL; c++)
            for (int l = 0; l < NROW; l++) job_w[c][l*BW +: BW] = BW'($urandom);
        start = 1'b1; loadW = 1'b1;
        @(negedge clock);
        start = 1'b0; loadW = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 50 && k < 3; cyc++) begin
            wIn_valid = 1'b1; wIn_data = job_w[k];
            acc = (wIn_ready === 1'b1);
            @(negedge clock);
            if (acc) k++;
        end
        #2 reset = 1'b1;
        #1;
        check_i("midload_reset_outputs", int'({busy, writeEn, wIn_ready, xIn_ready, outValid, err, dpReset}), 1);
        check_v("midload_reset_outvec", outVec, '0);
        @(negedge clock);
        reset = 1'b0; wIn_valid = 1'b0;
        @(negedge clock);
        for (int c = 0; c < NCOL; c++) job_x[c] = BW'($urandom);
        start_and_load(1'b1, 1'b0);
        compute_and_out(1, 0, got);
        check_v("after_reset_outvec", got, dot_ref(model_w, job_x));
        check_i("after_reset_write_count", wr_cols.size(), NCOL);
        check_i("after_reset_write_order", wr_order_bad(), 0);

        // Randomised jobs against the reference model.
        for (int j = 0; j < 6; j++) begin
            bit lw;
            lw = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int c = 0; c < NCOL; c++) begin
                for (int l = 0; l < NROW; l++) job_w[c][l*BW +: BW] = BW'($urandom);
                job_x[c] = BW'($urandom);
            end
            start_and_load(lw, 1'($urandom_range(0, 1)));
            compute_and_out(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), got);
            expv = dot_ref(model_w, job_x);
            check_v("rand_outvec", got, expv);
            check_i("rand_write_count", wr_cols.size(), lw ? NCOL : 0);
        end

        check_i("writes_during_compute", wr_overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
